// File: rtl/dcache_pkg.sv
// Shared types and helpers for the 2-way write-through data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        UNC_RD,
        WR
    } state_t;

    // kseg1 I/O window folded onto its physical alias
    localparam logic [15:0] REMAP_FROM = 16'hbfaf;
    localparam logic [15:0] REMAP_TO   = 16'h1faf;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_word[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dcache_way.sv
// One way of the cache: valid bits, tags and line data, read combinationally.
module dcache_way
    import dcache_pkg::*;
#(
    parameter int unsigned C_INDEX = 6,
    parameter int unsigned OFF_W   = 2,
    parameter int unsigned T_WIDTH = 22
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [C_INDEX-1:0] index,
    input  logic [OFF_W-1:0]   offset,
    input  logic               fill_we,
    input  logic [OFF_W-1:0]   fill_off,
    input  logic [31:0]        fill_data,
    input  logic               fill_done,
    input  logic [T_WIDTH-1:0] fill_tag,
    input  logic               merge_we,
    input  logic [31:0]        merge_data,
    input  logic [3:0]         merge_be,
    output logic [T_WIDTH-1:0] tag,
    output logic               valid,
    output logic [31:0]        word
);

    localparam int unsigned SETS  = 2 ** C_INDEX;
    localparam int unsigned WORDS = 2 ** OFF_W;

    logic [SETS-1:0]    valid_q;
    logic [T_WIDTH-1:0] tag_q  [SETS];
    logic [31:0]        data_q [SETS][WORDS];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            valid_q <= '0;
        end else if (fill_done) begin
            valid_q[index] <= 1'b1;
        end
    end

    // Refill beats and store merges never coincide: one is REFILL, the other WR.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_q[index] <= fill_tag;
        end
        if (fill_we) begin
            data_q[index][fill_off] <= fill_data;
        end else if (merge_we) begin
            data_q[index][offset] <= byte_merge(data_q[index][offset], merge_data, merge_be);
        end
    end

    assign tag   = tag_q[index];
    assign valid = valid_q[index];
    assign word  = data_q[index][offset];

endmodule

// File: rtl/d_cache_2way.sv
// 2-way set-associative write-through data cache with burst refill, 1-bit LRU,
// uncached bypass and exception-flush abort.
module d_cache_2way
    import dcache_pkg::*;
#(
    parameter int unsigned A_WIDTH = 32,
    parameter int unsigned C_INDEX = 6,
    parameter int unsigned OFF_W   = 2
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [A_WIDTH-1:0] p_a,
    input  logic [31:0]        p_dout,
    input  logic               p_strobe,
    input  logic               p_rw,
    input  logic [3:0]         p_wen,
    input  logic [3:0]         p_ren,
    input  logic               flush_except,
    input  logic               no_dcache,
    output logic               p_ready,
    output logic [31:0]        p_din,
    input  logic [31:0]        m_dout,
    input  logic               m_ready,
    output logic [31:0]        m_din,
    output logic [A_WIDTH-1:0] m_a,
    output logic               m_strobe,
    output logic               m_rw
);

    localparam int unsigned T_WIDTH    = A_WIDTH - C_INDEX - OFF_W - 2;
    localparam int unsigned LINE_WORDS = 2 ** OFF_W;
    localparam int unsigned SETS       = 2 ** C_INDEX;

    function automatic logic [A_WIDTH-1:0] remap(input logic [A_WIDTH-1:0] a);
        if (a[A_WIDTH-1 -: 16] == REMAP_FROM) return {REMAP_TO, a[A_WIDTH-17:0]};
        return a;
    endfunction

    state_t             state;
    logic [OFF_W-1:0]   cnt;
    logic               victim;
    logic [SETS-1:0]    lru;

    logic [C_INDEX-1:0] index;
    logic [OFF_W-1:0]   offset;
    logic [T_WIDTH-1:0] tag;
    logic [T_WIDTH-1:0] tag0, tag1;
    logic               valid0, valid1;
    logic [31:0]        word0, word1;
    logic               hit0, hit1, hit, last;
    logic               refill_beat, wr_hit;
    logic               fill_we0, fill_we1;
    logic               unused_ren;

    assign index  = p_a[C_INDEX+OFF_W+1 -: C_INDEX];
    assign offset = p_a[OFF_W+1 -: OFF_W];
    assign tag    = p_a[A_WIDTH-1 -: T_WIDTH];

    assign hit0 = valid0 & (tag0 == tag);
    assign hit1 = valid1 & (tag1 == tag);
    assign hit  = (hit0 | hit1) & ~no_dcache & ~flush_except;
    assign last = (cnt == OFF_W'(LINE_WORDS - 1));

    assign refill_beat = (state == REFILL) & m_ready & ~flush_except;
    assign wr_hit      = (state == WR) & m_ready & hit;
    assign fill_we0    = refill_beat & ~victim;
    assign fill_we1    = refill_beat & victim;

    assign m_din      = p_dout;
    assign unused_ren = ^p_ren;

    dcache_way #(.C_INDEX(C_INDEX), .OFF_W(OFF_W), .T_WIDTH(T_WIDTH)) u_way0 (
        .clk        (clk),
        .clrn       (clrn),
        .index      (index),
        .offset     (offset),
        .fill_we    (fill_we0),
        .fill_off   (cnt),
        .fill_data  (m_dout),
        .fill_done  (fill_we0 & last),
        .fill_tag   (tag),
        .merge_we   (wr_hit & hit0),
        .merge_data (p_dout),
        .merge_be   (p_wen),
        .tag        (tag0),
        .valid      (valid0),
        .word       (word0)
    );

    dcache_way #(.C_INDEX(C_INDEX), .OFF_W(OFF_W), .T_WIDTH(T_WIDTH)) u_way1 (
        .clk        (clk),
        .clrn       (clrn),
        .index      (index),
        .offset     (offset),
        .fill_we    (fill_we1),
        .fill_off   (cnt),
        .fill_data  (m_dout),
        .fill_done  (fill_we1 & last),
        .fill_tag   (tag),
        .merge_we   (wr_hit & hit1),
        .merge_data (p_dout),
        .merge_be   (p_wen),
        .tag        (tag1),
        .valid      (valid1),
        .word       (word1)
    );

    // LRU bit names the way to evict next; a hit on way0 points it at way1.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state  <= IDLE;
            cnt    <= '0;
            victim <= 1'b0;
            lru    <= '0;
        end else if (flush_except) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (p_strobe) begin
                        if (p_rw) begin
                            state <= WR;
                        end else if (no_dcache) begin
                            state <= UNC_RD;
                        end else if (hit) begin
                            lru[index] <= hit0;
                        end else begin
                            state  <= REFILL;
                            cnt    <= '0;
                            victim <= valid0 ? (valid1 ? lru[index] : 1'b1) : 1'b0;
                        end
                    end
                end
                REFILL: begin
                    if (m_ready) begin
                        cnt <= cnt + OFF_W'(1);
                        if (last) begin
                            state      <= IDLE;
                            lru[index] <= ~victim;
                        end
                    end
                end
                UNC_RD: begin
                    if (m_ready) state <= IDLE;
                end
                WR: begin
                    if (m_ready) begin
                        state <= IDLE;
                        if (hit) lru[index] <= hit0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs are decoded from state so hits and bus beats complete same-cycle.
    always_comb begin
        p_ready  = 1'b0;
        m_strobe = 1'b0;
        m_rw     = 1'b0;
        m_a      = remap(p_a);
        p_din    = hit1 ? word1 : word0;
        case (state)
            IDLE: begin
                p_ready = p_strobe & ~p_rw & hit;
            end
            REFILL: begin
                m_strobe = 1'b1;
                m_a      = remap({p_a[A_WIDTH-1:OFF_W+2], cnt, 2'b00});
            end
            UNC_RD: begin
                m_strobe = 1'b1;
                p_ready  = m_ready;
                p_din    = m_dout;
            end
            WR: begin
                m_strobe = 1'b1;
                m_rw     = 1'b1;
                p_ready  = m_ready;
            end
            default: ;
        endcase
        if (flush_except) begin
            p_ready  = 1'b0;
            m_strobe = 1'b0;
            m_rw     = 1'b0;
        end
    end

endmodule

// File: tb/tb_d_cache_2way.sv
// Bench for d_cache_2way: directed scenarios then random traffic against a
// set/way/recency model of the cache and a word-addressed memory model.
module tb_d_cache_2way;

    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] p_a, p_dout, p_din, m_dout, m_din, m_a;
    logic        p_strobe, p_rw, flush_except, no_dcache, p_ready;
    logic        m_ready, m_strobe, m_rw;
    logic [3:0]  p_wen, p_ren;

    d_cache_2way dut (
        .clk          (clk),
        .clrn         (clrn),
        .p_a          (p_a),
        .p_dout       (p_dout),
        .p_strobe     (p_strobe),
        .p_rw         (p_rw),
        .p_wen        (p_wen),
        .p_ren        (p_ren),
        .flush_except (flush_except),
        .no_dcache    (no_dcache),
        .p_ready      (p_ready),
        .p_din        (p_din),
        .m_dout       (m_dout),
        .m_ready      (m_ready),
        .m_din        (m_din),
        .m_a          (m_a),
        .m_strobe     (m_strobe),
        .m_rw         (m_rw)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [logic [31:0]];
    bit          rand_ready = 1'b0;
    logic [31:0] beat_a[$];
    logic [31:0] beat_din[$];
    logic        beat_rw[$];

    // cache model: per set two ways; mlru names the least recently used way
    bit          mv  [64][2];
    logic [31:0] mt  [64][2];
    logic [31:0] md  [64][2][4];
    int          mlru[64];

    function automatic logic [31:0] remap_a(input logic [31:0] a);
        if ((a >> 16) == 32'h0000_bfaf) return 32'h1faf_0000 | (a & 32'h0000_ffff);
        return a;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] k;
        k = a & ~32'h3;
        if (mem.exists(k)) return mem[k];
        return {k[15:0], ~k[15:0]} ^ 32'h0f0f_3c3c;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 64; s++) begin
            mv[s][0] = 1'b0;
            mv[s][1] = 1'b0;
            mlru[s]  = 0;
        end
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // memory side: accepts each strobed beat (always, or at random) and logs it
    initial begin
        m_ready = 1'b0;
        m_dout  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (m_strobe === 1'b1 && (!rand_ready || $urandom_range(0, 1) == 1)) begin
                m_ready = 1'b1;
                m_dout  = mem_rd(m_a);
                beat_a.push_back(m_a);
                beat_rw.push_back(m_rw);
                beat_din.push_back(m_din);
            end else begin
                m_ready = 1'b0;
                m_dout  = $urandom;
            end
        end
    end

    task automatic clear_beats();
        beat_a.delete();
        beat_rw.delete();
        beat_din.delete();
    endtask

    // One CPU access, checked against the model; model updated afterwards.
    task automatic access(input logic [31:0] a, input logic rw, input logic [31:0] d,
                          input logic [3:0] be, input logic nc,
                          output logic [31:0] rdata, output int ncyc);
        int          set, off, way, vic, exp_cyc;
        logic [31:0] tg, exp_data, k;
        logic [31:0] exp_a[$];
        bit          is_hit, done;
        set = int'((a >> 4) & 32'h3f);
        off = int'((a >> 2) & 32'h3);
        tg  = a >> 10;
        way = -1;
        if (mv[set][0] && mt[set][0] == tg) way = 0;
        else if (mv[set][1] && mt[set][1] == tg) way = 1;
        is_hit   = 1'b0;
        exp_data = '0;
        exp_cyc  = 1;
        if (rw || nc) begin
            exp_a.push_back(remap_a(a));
            exp_data = mem_rd(remap_a(a));
        end else if (way >= 0) begin
            is_hit   = 1'b1;
            exp_data = md[set][way][off];
            exp_cyc  = 0;
        end else begin
            for (int i = 0; i < 4; i++) exp_a.push_back(remap_a((a & ~32'hf) + 32'(4 * i)));
            exp_data = mem_rd(remap_a(a));
            exp_cyc  = 5;
        end

        @(negedge clk);
        p_a = a; p_rw = rw; p_dout = d; p_wen = be; p_ren = 4'hf;
        no_dcache = nc; p_strobe = 1'b1;
        clear_beats();
        rdata = 'x; ncyc = -1; done = 1'b0;
        for (int c = 0; c <= 200; c++) begin
            #2;
            if (is_hit && c == 0) chk("hit_mstrobe", 32'(m_strobe), 32'd0);
            if (p_ready === 1'b1) begin
                rdata = p_din; ncyc = c; done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) chk("timeout_pready", 32'(p_ready), 32'd1);
        @(negedge clk);
        p_strobe = 1'b0;

        if (!rw) chk("rdata", rdata, exp_data);
        chk("nbeats", 32'(beat_a.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < beat_a.size(); i++) begin
            chk("beat_addr", beat_a[i], exp_a[i]);
            chk("beat_rw", 32'(beat_rw[i]), 32'(rw));
            if (rw) chk("beat_din", beat_din[i], d);
        end
        if (!rand_ready || is_hit) chk("latency", 32'(ncyc), 32'(exp_cyc));

        if (rw) begin
            if (!nc && way >= 0) begin
                md[set][way][off] = merge(md[set][way][off], d, be);
                mlru[set] = 1 - way;
            end
            k = remap_a(a) & ~32'h3;
            mem[k] = merge(mem_rd(k), d, be);
        end else if (!nc) begin
            if (way >= 0) begin
                mlru[set] = 1 - way;
            end else begin
                vic = !mv[set][0] ? 0 : (!mv[set][1] ? 1 : mlru[set]);
                for (int i = 0; i < 4; i++) md[set][vic][i] = mem_rd(exp_a[i]);
                mv[set][vic] = 1'b1;
                mt[set][vic] = tg;
                mlru[set]    = 1 - vic;
            end
        end
    endtask

    initial begin
        logic [31:0] rd, a, d;
        int          cyc, r;
        clrn = 1'b0; p_a = '0; p_dout = '0; p_strobe = 1'b0; p_rw = 1'b0;
        p_wen = '0; p_ren = '0; flush_except = 1'b0; no_dcache = 1'b0;
        model_reset();
        #2;
        chk("reset_pready", 32'(p_ready), 32'd0);
        chk("reset_mstrobe", 32'(m_strobe), 32'd0);
        chk("reset_mrw", 32'(m_rw), 32'd0);
        @(negedge clk);
        clrn = 1'b1;

        // first refill and a following same-line hit
        mem[32'h40] = 32'h11; mem[32'h44] = 32'h22; mem[32'h48] = 32'h33; mem[32'h4c] = 32'h44;
        access(32'h40, 1'b0, '0, 4'h0, 1'b0, rd, cyc);
        chk("refill_rdata", rd, 32'h11);
        chk("refill_beat3", (beat_a.size() == 4) ? beat_a[3] : 32'hx, 32'h4c);
        access(32'h48, 1'b0, '0, 4'h0, 1'b0, rd, cyc);
        chk("hit_rdata", rd, 32'h33);

        // associativity and LRU replacement within set 4
        access(32'h1040, 1'b0, '0, 4'h0, 1'b0, rd, cyc);
        access(32'h40,   1'b0, '0, 4'h0, 1'b0, rd, cyc);
        access(32'h2040, 1'b0, '0, 4'h0, 1'b0, rd, cyc);
        access(32'h40,   1'b0, '0, 4'h0, 1'b0, rd, cyc);
        chk("lru_keep_beats", 32'(beat_a.size()), 32'd0);
        access(32'h1040, 1'b0, '0, 4'h0, 1'b0, rd, cyc);
        chk("lru_evict_beats", 32'(beat_a.size()), 32'd4);

        // write hit merges, write miss does not allocate
        mem[32'h100] = 32'h1122_3344;
        access(32'h100, 1'b0, '0, 4'h0, 1'b0, rd, cyc);
        access(32'h100, 1'b1, 32'hAABB_CCDD, 4'b0100, 1'b0, rd, cyc);
        chk("wr_din", (beat_din.size() > 0) ? beat_din[0] : 32'hx, 32'hAABB_CCDD);
        access(32'h100, 1'b0, '0, 4'h0, 1'b0, rd, cyc);
        chk("wr_merge_rdata", rd, 32'h11BB_3344);
        access(32'h3100, 1'b1, 32'h0102_0304, 4'hf, 1'b0, rd, cyc);
        access(32'h3100, 1'b0, '0, 4'h0, 1'b0, rd, cyc);
        chk("wr_noalloc_beats", 32'(beat_a.size()), 32'd4);

        // uncached reads through the remapped window
        mem[32'h1faf_0010] = 32'hCAFE_F00D;
        access(32'hbfaf_0010, 1'b0, '0, 4'h0, 1'b1, rd, cyc);
        chk("unc_addr", (beat_a.size() > 0) ? beat_a[0] : 32'hx, 32'h1faf_0010);
        chk("unc_rdata", rd, 32'hCAFE_F00D);
        access(32'hbfaf_0010, 1'b0, '0, 4'h0, 1'b1, rd, cyc);
        chk("unc_again_beats", 32'(beat_a.size()), 32'd1);

        // flush after two refill beats
        @(negedge clk);
        p_a = 32'h80; p_rw = 1'b0; no_dcache = 1'b0; p_strobe = 1'b1;
        clear_beats();
        repeat (3) @(negedge clk);
        flush_except = 1'b1;
        #2;
        chk("flush_mstrobe", 32'(m_strobe), 32'd0);
        chk("flush_pready", 32'(p_ready), 32'd0);
        chk("flush_beats", 32'(beat_a.size()), 32'd2);
        @(negedge clk);
        flush_except = 1'b0; p_strobe = 1'b0;
        #2;
        chk("flush_idle", 32'(m_strobe), 32'd0);
        access(32'h80, 1'b0, '0, 4'h0, 1'b0, rd, cyc);
        chk("flush_refill_beats", 32'(beat_a.size()), 32'd4);

        // asynchronous reset during a refill
        @(negedge clk);
        p_a = 32'hC0; p_rw = 1'b0; no_dcache = 1'b0; p_strobe = 1'b1;
        clear_beats();
        repeat (2) @(negedge clk);
        #2;
        chk("pre_rst_mstrobe", 32'(m_strobe), 32'd1);
        #1 clrn = 1'b0;
        #1;
        chk("rst_mstrobe", 32'(m_strobe), 32'd0);
        chk("rst_pready", 32'(p_ready), 32'd0);
        @(negedge clk);
        p_strobe = 1'b0; clrn = 1'b1;
        model_reset();
        access(32'h40, 1'b0, '0, 4'h0, 1'b0, rd, cyc);
        chk("post_rst_beats", 32'(beat_a.size()), 32'd4);

        // random traffic over a few colliding tags in four sets
        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            a = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 3)) << 4)
              | (32'($urandom_range(0, 3)) << 2);
            d = $urandom;
            if (r < 6)
                access(a, 1'b0, '0, 4'h0, 1'b0, rd, cyc);
            else if (r < 8)
                access(a, 1'b1, d, 4'($urandom_range(1, 15)), 1'($urandom_range(0, 3) == 0), rd, cyc);
            else
                access(a, 1'b0, '0, 4'h0, 1'b1, rd, cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/d_cache_2way.md
Name: d_cache_2way

Overview:
- Parametrised successor to the direct-mapped write-through data cache between the MEM stage and the memory bus.
- Organisation: 2-way set-associative, multi-word lines, burst refill on read miss, 1-bit LRU per set.
- Write policy: write-through, no-allocate.
- Also provides a bypass path for uncached (kseg1) accesses and aborts cleanly on exception flush.

Parameters:
- A_WIDTH, 32, address width.
- C_INDEX, 6, log2 of set count (64 sets).
- OFF_W, 2, log2 of words per line (LINE_WORDS = 4). Tag width T_WIDTH = A_WIDTH-C_INDEX-OFF_W-2.

Ports:
- clk  in  1  clock
- clrn  in  1  reset, asynchronous, active-low
- p_a  in  A_WIDTH  CPU byte address
- p_dout  in  32  CPU store data
- p_strobe  in  1  access request, held until p_ready
- p_rw  in  1  0 read, 1 write
- p_wen  in  4  store byte enables
- p_ren  in  4  load byte enables (informational; full word always returned)
- flush_except  in  1  exception flush, abort current access
- no_dcache  in  1  uncached access
- p_ready  out  1  access complete this cycle
- p_din  out  32  load data, valid when p_ready & ~p_rw
- m_dout  in  32  memory read data
- m_ready  in  1  memory beat complete
- m_din  out  32  memory write data (= p_dout)
- m_a  out  A_WIDTH  memory word address, after remap
- m_strobe  out  1  memory request
- m_rw  out  1  memory write

Behaviour:
- Reset (clrn=0, async):
  - All valid bits and LRU bits are 0; state is IDLE; beat counter is 0.
  - p_ready=0, m_strobe=0, m_rw=0.
- Address remap (all memory traffic): p_a[31:16]==16'hbfaf → m_a = {16'h1faf, low 16 bits}; otherwise m_a passes through.
- Address fields: index = p_a[C_INDEX+OFF_W+1 : OFF_W+2]; word offset = p_a[OFF_W+1:2]; tag = upper bits.
- hit_w = valid_w[index] & (tag_w[index]==tag). hit = (hit0|hit1) & ~no_dcache & ~flush_except.
- IDLE state:
  - Read hit: p_ready=1 in the same cycle, zero wait. p_din = selected word of the hit way. LRU[index] is set to point at the way not hit. Stay in IDLE.
  - Read miss, cacheable: go to REFILL with beat counter=0. Victim is the first invalid way (way0 preferred), otherwise the way given by LRU[index].
  - Read, no_dcache=1: go to UNC_RD.
  - Write (any cacheability): go to WR.
- REFILL state:
  - Outputs: m_strobe=1, m_rw=0, m_a = remap({line base, counter, 2'b00}).
  - On each m_ready: write m_dout into victim data[index][counter] and increment the counter.
  - On the last beat (counter==LINE_WORDS-1 with m_ready): set victim valid and tag; set LRU to the other way; go to IDLE.
  - The next cycle is then a hit and raises p_ready.
  - Read-miss latency = LINE_WORDS memory beats + 1 cycle.
- UNC_RD state:
  - Outputs: m_strobe=1, m_rw=0, m_a = remap(p_a).
  - On m_ready: p_ready=1 and p_din=m_dout in the same cycle; go to IDLE. The cache is untouched.
- WR state:
  - Outputs: m_strobe=1, m_rw=1, m_a = remap(p_a), m_din=p_dout.
  - On m_ready: p_ready=1; go to IDLE.
  - In the same cycle, if hit, merge p_dout bytes selected by p_wen into the hit way word; LRU points to the other way.
  - Write miss or no_dcache: no allocation, cache unchanged.
- flush_except (any state):
  - Combinationally forces p_ready=0 and m_strobe=0, and suppresses all cache array and LRU writes.
  - Next state is IDLE; a partially refilled line stays invalid.
- While p_strobe=0 in IDLE: m_strobe=0 and p_ready=0.
- p_a, p_rw and p_wen must be held stable by the CPU until p_ready; the cache does not latch them.
- Counter wraps from LINE_WORDS-1 to 0 only on refill completion.
- Each way's valid bit changes only on refill completion or reset.

Decomposition:
- Package dcache_pkg:
  - state enum {IDLE, REFILL, UNC_RD, WR};
  - remap constants 16'hbfaf / 16'h1faf;
  - helper function for the byte-enable merge.
- One sub-module, dcache_way: per-way tag/valid/data arrays.
  - Ports: index, word offset, refill write port, byte-merge write port.
  - Outputs: combinational read of tag, valid and word.
  - Instantiated twice. The top level holds the FSM, counter, LRU array and muxing.

Test Plan:
- Reset, then read 0x00000040 → REFILL issues m_a 0x40, 0x44, 0x48, 0x4C (m_dout 0x11, 0x22, 0x33, 0x44). p_ready comes one cycle after the last beat with p_din=0x11. A read of 0x48 is then a same-cycle hit returning 0x33 with m_strobe=0.
- Associativity and LRU: fill way0 at 0x40, fill way1 at 0x1040 (same index), re-read 0x40 (hit), then read 0x2040 → way1 (0x1040) is evicted. Check: 0x40 still hits; 0x1040 misses.
- Write hit: cached word 0x11223344, store 0xAABBCCDD with p_wen=4'b0100 → one write beat with m_rw=1 and m_din=0xAABBCCDD. A subsequent read returns 0x11BB3344 with no memory access. A write miss must not allocate: the next read misses.
- Uncached: read 0xbfaf0010 with no_dcache=1 → m_a=0x1faf0010, p_din=m_dout. A second read goes to memory again (no allocation).
- Flush mid-refill: assert flush_except after 2 of 4 beats → m_strobe drops combinationally, state returns to IDLE. Re-reading the same line performs a full 4-beat refill.
- Async reset mid-REFILL: drop clrn → m_strobe=0 and p_ready=0 immediately. All lines are invalid after release.
